// File: rtl/ysyx_25020037_issue_ctrl.sv
// Issue/hazard scheduler between IDU and EXU: per-GPR write scoreboard, load-use gating,
// redirect flush sequencing and fence.i drain with icache invalidate.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | normal issue, gated by hazards and lsu_ready
// FLUSH | front end squashed, hold idu_ready low for FLUSH_CYC cycles
// FENCE | fence.i issued, wait for every in-flight write to retire
// ICF   | icache invalidate in progress, wait for icache_flush_done
module ysyx_25020037_issue_ctrl #(
    parameter int NREG      = 16,
    parameter int RIDX_W    = 4,
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idu_valid,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [RIDX_W-1:0] rd,
    input  logic              gpr_we,
    input  logic              inst_l,
    input  logic              is_fence_i,
    input  logic              lsu_ready,
    input  logic              load_done,
    input  logic [RIDX_W-1:0] load_rd,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              redirect,
    input  logic              icache_flush_done,
    output logic              idu_ready,
    output logic              issue_fire,
    output logic              flush_front,
    output logic              icache_flush,
    output logic              busy,
    output logic              sb_err
);

    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_FENCE,
        S_ICF
    } state_t;

    state_t            state, state_nxt;
    logic [FC_W-1:0]   fc, fc_nxt;

    logic [CNT_W-1:0]  pend     [NREG];
    logic [CNT_W-1:0]  pend_nxt [NREG];
    logic [NREG-1:0]   lpend, lpend_nxt;
    logic              err_set;

    logic [NREG-1:0]   inc_v, dec_v, lset_v, lclr_v;
    logic              hz, waw, sat;

    assign hz  = (rs1_used && rs1 != '0 && lpend[rs1]) ||
                 (rs2_used && rs2 != '0 && lpend[rs2]);
    assign waw = gpr_we && rd != '0 && lpend[rd];
    assign sat = gpr_we && rd != '0 && (pend[rd] == {CNT_W{1'b1}});

    assign idu_ready  = (state == S_RUN) && !redirect && lsu_ready && !hz && !waw && !sat;
    assign issue_fire = idu_valid && idu_ready;

    // One-hot per-register event vectors; x0 never produces an event.
    assign inc_v  = (issue_fire && gpr_we && rd != '0) ? (NREG'(1) << rd) : '0;
    assign lset_v = (issue_fire && gpr_we && inst_l && rd != '0) ? (NREG'(1) << rd) : '0;
    assign dec_v  = (wb_valid && wb_rd != '0) ? (NREG'(1) << wb_rd) : '0;
    assign lclr_v = (load_done && load_rd != '0) ? (NREG'(1) << load_rd) : '0;

    always_comb begin
        err_set   = 1'b0;
        lpend_nxt = (lpend & ~lclr_v) | lset_v;
        lpend_nxt[0] = 1'b0;
        busy      = |lpend;
        for (int r = 0; r < NREG; r++) begin
            pend_nxt[r] = pend[r];
            busy        = busy | (pend[r] != '0);
            if (r == 0) begin
                pend_nxt[r] = '0;
            end else if (inc_v[r] && !dec_v[r]) begin
                pend_nxt[r] = pend[r] + CNT_W'(1);
            end else if (dec_v[r] && !inc_v[r]) begin
                if (pend[r] == '0) err_set = 1'b1;
                else               pend_nxt[r] = pend[r] - CNT_W'(1);
            end
            if (lclr_v[r] && !lpend[r]) err_set = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        fc_nxt       = fc;
        flush_front  = 1'b0;
        icache_flush = 1'b0;
        case (state)
            S_RUN: begin
                if (redirect) begin
                    state_nxt   = S_FLUSH;
                    fc_nxt      = FC_W'(FLUSH_CYC);
                    flush_front = 1'b1;
                end else if (issue_fire && is_fence_i) begin
                    state_nxt = S_FENCE;
                end
            end
            S_FLUSH: begin
                if (redirect) begin
                    fc_nxt      = FC_W'(FLUSH_CYC);
                    flush_front = 1'b1;
                end else if (fc == FC_W'(1)) begin
                    state_nxt = S_RUN;
                end else begin
                    fc_nxt = fc - FC_W'(1);
                end
            end
            S_FENCE: begin
                if (!busy) begin
                    state_nxt    = S_ICF;
                    icache_flush = 1'b1;
                end
            end
            S_ICF: begin
                if (icache_flush_done) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_RUN;
            fc     <= '0;
            pend   <= '{default: '0};
            lpend  <= '0;
            sb_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            fc     <= fc_nxt;
            pend   <= pend_nxt;
            lpend  <= lpend_nxt;
            sb_err <= sb_err | err_set;
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_issue_ctrl.sv
// Directed bench for ysyx_25020037_issue_ctrl; expected output vectors are queued as each
// step is driven and compared against the DUT at the following falling edge.
module tb_ysyx_25020037_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       idu_valid, rs1_used, rs2_used, gpr_we, inst_l, is_fence_i;
    logic       lsu_ready, load_done, wb_valid, redirect, icache_flush_done;
    logic [3:0] rs1, rs2, rd, load_rd, wb_rd;
    logic       idu_ready, issue_fire, flush_front, icache_flush, busy, sb_err;

    int checks = 0;
    int errors = 0;

    // Vector order: {idu_ready, issue_fire, flush_front, icache_flush, busy, sb_err}
    logic [5:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    ysyx_25020037_issue_ctrl dut (
        .clk(clk), .rst(rst), .idu_valid(idu_valid), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .gpr_we(gpr_we),
        .inst_l(inst_l), .is_fence_i(is_fence_i), .lsu_ready(lsu_ready),
        .load_done(load_done), .load_rd(load_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .redirect(redirect), .icache_flush_done(icache_flush_done),
        .idu_ready(idu_ready), .issue_fire(issue_fire), .flush_front(flush_front),
        .icache_flush(icache_flush), .busy(busy), .sb_err(sb_err)
    );

    task automatic idle();
        idu_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        rd = 0; gpr_we = 0; inst_l = 0; is_fence_i = 0; lsu_ready = 1;
        load_done = 0; load_rd = 0; wb_valid = 0; wb_rd = 0;
        redirect = 0; icache_flush_done = 0;
    endtask

    task automatic iss(input logic [3:0] d, input logic we, input logic ld);
        idu_valid = 1; rd = d; gpr_we = we; inst_l = ld;
    endtask

    task automatic wb(input logic [3:0] d);
        wb_valid = 1; wb_rd = d;
    endtask

    task automatic step(input string tag, input logic [5:0] exp);
        logic [5:0] obs, e;
        string      t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {idu_ready, issue_fire, flush_front, icache_flush, busy, sb_err};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", t, obs, e);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        step("reset", 6'b100000);
        rst = 1;

        // load-use stall on x5
        iss(5, 1, 1);                          step("lw_x5_issue", 6'b110000);
        iss(6, 1, 0); rs1 = 5; rs1_used = 1;   step("use_x5_stall", 6'b000010);
        iss(6, 1, 0); rs1 = 5; rs1_used = 1;
        load_done = 1; load_rd = 5;            step("load_done_cycle", 6'b000010);
        iss(6, 1, 0); rs1 = 5; rs1_used = 1;   step("use_x5_fire", 6'b110010);
        wb(5);                                 step("wb_x5", 6'b100010);
        wb(6);                                 step("wb_x6", 6'b100010);
        step("drained_1", 6'b100000);

        // in-flight counter saturation on x3
        iss(3, 1, 0);                          step("x3_w1", 6'b110000);
        iss(3, 1, 0);                          step("x3_w2", 6'b110010);
        iss(3, 1, 0);                          step("x3_w3", 6'b110010);
        iss(3, 1, 0);                          step("x3_sat", 6'b000010);
        iss(3, 1, 0); wb(3);                   step("x3_sat_wb", 6'b000010);
        iss(3, 1, 0);                          step("x3_after_wb", 6'b110010);
        wb(3);                                 step("x3_wb_a", 6'b100010);
        wb(3);                                 step("x3_wb_b", 6'b100010);
        wb(3);                                 step("x3_wb_c", 6'b100010);
        step("drained_2", 6'b100000);

        // redirect flush, scoreboard kept across it
        iss(8, 1, 0);                          step("x8_issue", 6'b110000);
        idu_valid = 1; redirect = 1;           step("redir_1", 6'b001010);
        idu_valid = 1;                         step("flush_1a", 6'b000010);
        idu_valid = 1;                         step("flush_1b", 6'b000010);
        idu_valid = 1;                         step("run_after_flush", 6'b110010);
        redirect = 1;                          step("redir_2", 6'b001010);
        step("flush_2a", 6'b000010);
        redirect = 1;                          step("redir_in_flush", 6'b001010);
        step("flush_2b", 6'b000010);
        step("flush_2c", 6'b000010);
        step("run_after_reflush", 6'b100010);
        wb(8);                                 step("wb_x8", 6'b100010);
        step("drained_3", 6'b100000);

        // fence.i drain and icache flush
        iss(7, 1, 0);                          step("x7_issue", 6'b110000);
        idu_valid = 1; is_fence_i = 1;         step("fence_issue", 6'b110010);
        idu_valid = 1;                         step("fence_wait", 6'b000010);
        redirect = 1;                          step("fence_redir_ignored", 6'b000010);
        wb(7);                                 step("fence_wb_x7", 6'b000010);
        step("icache_flush_pulse", 6'b000100);
        step("icf_1", 6'b000000);
        step("icf_2", 6'b000000);
        icache_flush_done = 1;                 step("icf_done", 6'b000000);
        idu_valid = 1;                         step("run_after_fence", 6'b110000);

        // simultaneous issue and retire on x4, then retire of untracked x9
        iss(4, 1, 0);                          step("x4_issue", 6'b110000);
        iss(4, 1, 0); wb(4);                   step("x4_issue_wb", 6'b110010);
        step("x4_still_pending", 6'b100010);
        wb(4);                                 step("x4_wb", 6'b100010);
        step("drained_4", 6'b100000);
        wb(9);                                 step("wb_x9_untracked", 6'b100000);
        step("sb_err_set", 6'b100001);
        step("sb_err_sticky", 6'b100001);

        // async reset in the middle of a fence
        iss(10, 1, 0);                         step("x10_issue", 6'b110001);
        idu_valid = 1; is_fence_i = 1;         step("fence2_issue", 6'b110011);
        step("fence2_wait", 6'b000011);
        rst = 0;                               step("async_reset", 6'b100000);
        rst = 0; lsu_ready = 0;                step("reset_lsu_low", 6'b000000);
        rst = 1;
        lsu_ready = 0;                         step("post_reset_lsu_low", 6'b000000);
        step("post_reset_lsu_high", 6'b100000);
        idu_valid = 1;                         step("post_reset_fire", 6'b110000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_issue_ctrl.md
Name: ysyx_25020037_issue_ctrl

Overview:
Issue/hazard scheduler between IDU and EXU of the ysyx_25020037 pipeline. Keeps a per-GPR scoreboard of in-flight writes and pending loads, and gates the IDU->EXU handshake on load-use and WAW-load hazards. Sequences front-end flush after a control redirect, and fence.i drain plus icache flush. Register forwarding remains in the EXU; this block only decides when an instruction may issue.

Parameters:
NREG, 16, number of architectural GPRs (RV32E); x0 is never tracked.
RIDX_W, 4, register index width (log2 NREG).
CNT_W, 2, width of the per-register in-flight counter; saturates at 2^CNT_W-1.
FLUSH_CYC, 2, cycles idu_ready is held low after a redirect.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (asserted at 0).
idu_valid  in  1  IDU presents a decoded instruction.
rs1 / rs2  in  RIDX_W each  source register indices.
rs1_used / rs2_used  in  1 each  source register is actually read.
rd  in  RIDX_W  destination register index.
gpr_we  in  1  instruction writes rd.
inst_l  in  1  instruction is a load.
is_fence_i  in  1  instruction is fence.i.
lsu_ready  in  1  downstream (EXU/LSU) can accept.
load_done  in  1  load data returned this cycle.
load_rd  in  RIDX_W  destination of the returned load.
wb_valid  in  1  WBU retires a GPR write this cycle.
wb_rd  in  RIDX_W  retired destination.
redirect  in  1  EXU dnpc_valid (taken jump, ecall, or mret).
icache_flush_done  in  1  icache invalidate complete.
idu_ready  out  1  block accepts an instruction this cycle.
issue_fire  out  1  idu_valid && idu_ready.
flush_front  out  1  one-cycle pulse: squash IFU/IDU contents.
icache_flush  out  1  one-cycle pulse: start icache invalidate.
busy  out  1  any pending counter is nonzero or any load is pending.
sb_err  out  1  sticky: retire or load_done on an untracked register.

Behaviour:
- Reset (rst=0, asynchronous): all counters and load_pend bits are 0; state=RUN; every output is 0 except idu_ready, which is combinational.
- State per register r in 1..NREG-1: pend[r] (CNT_W-bit) and lpend[r] (1 bit).
- Hazard terms:
  - hz = (rs1_used && rs1!=0 && lpend[rs1]) || (rs2_used && rs2!=0 && lpend[rs2]).
  - waw = gpr_we && rd!=0 && lpend[rd].
  - sat = gpr_we && rd!=0 && pend[rd] is at maximum.
- idu_ready = (state==RUN) && lsu_ready && !hz && !waw && !sat.
  - idu_ready does not depend on idu_valid.
  - idu_ready is forced to 0 in the cycle redirect=1.
- On issue_fire with gpr_we && rd!=0: pend[rd]++. If inst_l is also set, lpend[rd] is set.
- load_done && load_rd!=0: clear lpend[load_rd]. If the bit was already 0, set sb_err.
- wb_valid && wb_rd!=0: pend[wb_rd]--. If it was already 0, set sb_err and keep 0.
- Same register incremented and decremented in the same cycle: net unchanged.
- A newly issued load can never hit an lpend bit being cleared in the same cycle; waw prevents it.
- FSM:
  - RUN:
    - redirect=1 -> FLUSH: flush_front=1 that cycle; load flush counter with FLUSH_CYC.
    - Else, issue_fire && is_fence_i -> FENCE.
  - FLUSH: idu_ready=0; counter decrements; at 1 -> RUN. A redirect in FLUSH reloads the counter and pulses flush_front again. The scoreboard is not cleared, because already-issued instructions still retire.
  - FENCE: idu_ready=0; when busy==0 -> ICF with icache_flush=1 in the transition cycle. redirect is ignored.
  - ICF: idu_ready=0; wait for icache_flush_done=1 -> RUN. A done pulse arriving in the same cycle as entry is honoured next cycle.
- Reset mid-operation: immediate return to the reset state; any in-progress fence or flush is abandoned.
- busy = OR of all pend and lpend bits.
- sb_err is cleared only by reset.

Test Plan:
- Load-use stall: issue lw x5 (rd=5, inst_l=1). Next cycle: idu_valid, rs1=5, rs1_used=1 -> idu_ready=0. Pulse load_done with load_rd=5 -> idu_ready=1 the following cycle; issue_fire=1.
- Counter saturation: issue three addi to x3 with no wb (pend[3]=3). Fourth write to x3 -> idu_ready=0. One wb_valid with wb_rd=3 -> ready next cycle.
- Redirect: redirect=1 in RUN -> flush_front=1 for 1 cycle; idu_ready=0 for exactly 2 cycles; scoreboard unchanged. A second redirect during FLUSH extends the hold to 2 cycles from that point.
- fence.i: pend[7]=1 outstanding; issue fence.i -> idu_ready=0. wb x7 -> icache_flush pulses 1 cycle. icache_flush_done 3 cycles later -> RUN, idu_ready=1.
- Simultaneous events: issue to x4 with wb_rd=4 in the same cycle and pend[4]=1 -> pend[4] stays 1 and busy=1. wb_rd=9 with pend[9]=0 -> sb_err=1 and stays set.
- Async reset: assert rst=0 mid-FENCE -> outputs 0 and busy=0 immediately. After release, idu_ready follows lsu_ready.
